// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus bridge.
package sys_bus_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned INTR_W = 6;
  localparam int unsigned SLOT_W = 3;
  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/sys_bus_decode.sv
// Combinational address decode: range hit, slot index and word alignment.
module sys_bus_decode
  import sys_bus_pkg::*;
#(
  parameter int unsigned N_DEV = 3,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned REG_AW = 2
) (
  input  logic [WORD_W-1:0] addr,
  output logic              hit,
  output logic [SLOT_W-1:0] slot,
  output logic              misaligned
);

  localparam int unsigned SLOT_SHIFT = REG_AW + 2;
  localparam logic [WORD_W-1:0] SPAN = WORD_W'(N_DEV) << SLOT_SHIFT;

  logic [WORD_W-1:0] offset;

  // Subtracting first keeps the upper bound free of overflow near the top of memory.
  assign offset     = addr - BASE_ADDR;
  assign hit        = (addr >= BASE_ADDR) && (offset < SPAN);
  assign slot       = SLOT_W'(offset >> SLOT_SHIFT);
  assign misaligned = |addr[1:0];

endmodule

// File: rtl/sys_bus_bridge.sv
// CPU data port to N_DEV memory-mapped devices: decode, req/ack with timeout, interrupt masking.
module sys_bus_bridge
  import sys_bus_pkg::*;
#(
  parameter int unsigned N_DEV = 3,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned REG_AW = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [INTR_W-1:0] INTR_MASK = 6'b111111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pr_req,
  input  logic                    pr_we,
  input  logic [WORD_W-1:0]       pr_addr,
  input  logic [WORD_W-1:0]       pr_wd,
  output logic [WORD_W-1:0]       pr_rd,
  output logic                    pr_ready,
  output logic                    pr_err,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [REG_AW-1:0]       dev_addr,
  output logic [WORD_W-1:0]       dev_wd,
  input  logic [N_DEV*WORD_W-1:0] dev_rd,
  input  logic [N_DEV-1:0]        dev_ack,
  input  logic [N_DEV-1:0]        dev_intr,
  output logic [INTR_W-1:0]       hw_intr
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (N_DEV < 1 || N_DEV > 6) begin : g_bad_n_dev
    $fatal(1, "sys_bus_bridge: N_DEV must be in 1..6");
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dec_hit;
  logic [SLOT_W-1:0] dec_slot;
  logic              dec_misaligned;
  logic              sel_ack;
  logic              timed_out;
  logic [WORD_W-1:0] sel_rd;
  logic [INTR_W-1:0] intr_d;

  sys_bus_decode #(
    .N_DEV    (N_DEV),
    .BASE_ADDR(BASE_ADDR),
    .REG_AW   (REG_AW)
  ) u_decode (
    .addr      (pr_addr),
    .hit       (dec_hit),
    .slot      (dec_slot),
    .misaligned(dec_misaligned)
  );

  // dev_sel is one-hot during ACCESS, so masking by it ignores acks from other slots.
  assign sel_ack   = |(dev_ack & dev_sel);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    sel_rd = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (dev_sel[k]) sel_rd = dev_rd[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    intr_d = '0;
    intr_d[N_DEV-1:0] = dev_intr & INTR_MASK[N_DEV-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pr_rd    <= '0;
      pr_ready <= 1'b0;
      pr_err   <= 1'b0;
      dev_sel  <= '0;
      dev_we   <= 1'b0;
      dev_addr <= '0;
      dev_wd   <= '0;
      hw_intr  <= '0;
    end else begin
      hw_intr  <= intr_d;
      pr_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pr_req) begin
            if (dec_hit && !dec_misaligned) begin
              dev_sel  <= N_DEV'(1) << dec_slot;
              dev_we   <= pr_we;
              dev_addr <= pr_addr[REG_AW+1:2];
              dev_wd   <= pr_wd;
              cnt_q    <= '0;
              state_q  <= StAccess;
            end else begin
              pr_err   <= 1'b1;
              pr_rd    <= '0;
              pr_ready <= 1'b1;
              state_q  <= StResp;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Ack is tested first so it wins over a timeout in the same cycle.
          if (sel_ack || timed_out) begin
            pr_rd    <= (sel_ack && !dev_we) ? sel_rd : '0;
            pr_err   <= !sel_ack;
            pr_ready <= 1'b1;
            dev_sel  <= '0;
            dev_we   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StResp;
          end
        end
        StResp: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Randomised scoreboard bench for sys_bus_bridge against an address-map reference model.
module tb_sys_bus_bridge;

  localparam int          NDEV = 3;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [5:0]  MASK = 6'b000001;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             pr_req, pr_we;
  logic [31:0]      pr_addr, pr_wd, pr_rd;
  logic             pr_ready, pr_err;
  logic [NDEV-1:0]  dev_sel;
  logic             dev_we;
  logic [1:0]       dev_addr;
  logic [31:0]      dev_wd;
  logic [NDEV*32-1:0] dev_rd;
  logic [NDEV-1:0]  dev_ack, dev_intr;
  logic [5:0]       hw_intr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  sys_bus_bridge #(
    .N_DEV    (NDEV),
    .BASE_ADDR(BASE),
    .REG_AW   (2),
    .TIMEOUT  (TMO),
    .INTR_MASK(MASK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pr_req  (pr_req),
    .pr_we   (pr_we),
    .pr_addr (pr_addr),
    .pr_wd   (pr_wd),
    .pr_rd   (pr_rd),
    .pr_ready(pr_ready),
    .pr_err  (pr_err),
    .dev_sel (dev_sel),
    .dev_we  (dev_we),
    .dev_addr(dev_addr),
    .dev_wd  (dev_wd),
    .dev_rd  (dev_rd),
    .dev_ack (dev_ack),
    .dev_intr(dev_intr),
    .hw_intr (hw_intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference address map: slot = 16-byte window above BASE, word aligned only.
  function automatic logic model_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + NDEV * 16) && (a % 4 == 0);
  endfunction

  function automatic logic [5:0] model_intr(input logic [NDEV-1:0] v);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = (k < NDEV) ? (v[k] & MASK[k]) : 1'b0;
    return r;
  endfunction

  // Response monitor: every pr_ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && pr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ready: got pr_ready=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pr_rd", pr_rd, mon_e.rd);
        check("pr_err", 32'(pr_err), 32'(mon_e.err));
        check("ready_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // waits = ACCESS cycles before the selected device acks; waits >= TMO means never.
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdata);
    logic        hit;
    int          slot;
    logic [31:0] t0;
    exp_t        e;
    hit  = model_hit(addr);
    slot = int'((addr - BASE) / 16);
    pr_req = 1'b1; pr_we = we; pr_addr = addr; pr_wd = wd;
    @(posedge clk); #1;
    t0 = cyc;
    if (!hit)             e = '{rd: 32'h0, err: 1'b1, cyc: t0};
    else if (waits < TMO) e = '{rd: (we ? 32'h0 : rdata), err: 1'b0, cyc: t0 + 1 + waits};
    else                  e = '{rd: 32'h0, err: 1'b1, cyc: t0 + TMO};
    exp_q.push_back(e);
    if (hit) begin
      for (int c = 0; c < TMO && c <= waits; c++) begin
        for (int k = 0; k < NDEV; k++) dev_rd[k*32 +: 32] = $urandom;
        dev_ack = NDEV'($urandom);
        dev_ack[slot] = 1'b0;
        if (c == waits) begin
          dev_ack[slot] = 1'b1;
          dev_rd[slot*32 +: 32] = rdata;
        end
        @(negedge clk);
        check("dev_sel", 32'(dev_sel), 32'(1 << slot));
        check("dev_we", 32'(dev_we), 32'(we));
        check("dev_addr", 32'(dev_addr), (addr % 16) / 4);
        check("dev_wd", dev_wd, wd);
        @(posedge clk); #1;
      end
      dev_ack = '0;
    end
    @(negedge clk);
    check("resp_dev_sel", 32'(dev_sel), 32'h0);
    @(posedge clk); #1;
    pr_req = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_ready: got no pr_ready expected one by cycle %0d", exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0]     a;
    logic [NDEV-1:0] v;
    logic [5:0]      prev;
    int              w;
    reset = 1'b1; pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0;
    dev_rd = '0; dev_ack = '0; dev_intr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pr_rd", pr_rd, 32'h0);
    check("rst_pr_ready", 32'(pr_ready), 32'h0);
    check("rst_pr_err", 32'(pr_err), 32'h0);
    check("rst_dev_sel", 32'(dev_sel), 32'h0);
    check("rst_dev_we", 32'(dev_we), 32'h0);
    check("rst_dev_addr", 32'(dev_addr), 32'h0);
    check("rst_dev_wd", dev_wd, 32'h0);
    check("rst_hw_intr", 32'(hw_intr), 32'h0);
    reset = 1'b0;

    access(32'h7F24, 1'b0, 32'h0, 0, 32'hCAFE_0001);
    access(32'h7F04, 1'b1, 32'h55, 3, 32'hDEAD_BEEF);
    access(32'h7F30, 1'b0, 32'h0, 0, 32'h1);
    access(32'h7F02, 1'b0, 32'h0, 0, 32'h2);
    access(32'h7EFC, 1'b1, 32'h3, 0, 32'h3);
    access(32'h7F10, 1'b0, 32'h0, TMO, 32'h4);
    access(32'h7F10, 1'b0, 32'h0, TMO - 1, 32'h1234_5678);
    access(32'h7F14, 1'b0, 32'h0, 2, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      a = BASE + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      w = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 4);
      access(a, 1'($urandom), $urandom, w, $urandom);
    end

    // Reset in the middle of an access: select drops at once and no response follows.
    pr_req = 1'b1; pr_we = 1'b0; pr_addr = 32'h7F10;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_access_sel", 32'(dev_sel), 32'h2);
    reset = 1'b1;
    #1;
    check("async_rst_sel", 32'(dev_sel), 32'h0);
    check("async_rst_ready", 32'(pr_ready), 32'h0);
    @(posedge clk); #1;
    pr_req = 1'b0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_sel", 32'(dev_sel), 32'h0);

    // Interrupts: one-cycle registered, statically masked.
    prev = hw_intr;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? NDEV'(3'b101) : NDEV'($urandom);
      dev_intr = v;
      #1;
      check("intr_hold", 32'(hw_intr), 32'(prev));
      @(posedge clk); #1;
      check("intr_new", 32'(hw_intr), 32'(model_intr(v)));
      prev = model_intr(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
